// File: rtl/b2b_pkg.sv
// Shared types and helpers for the board-to-board event router.
// Word classification and saturating counter arithmetic.
package b2b_pkg;

  localparam logic [1:0] META_HEADER = 2'b10;
  localparam logic [1:0] META_FOOTER = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STREAM,
    DROP
  } input_state_t;

  function automatic logic is_header(
    input logic       meta,
    input logic [1:0] kind
  );
    return meta && (kind == META_HEADER);
  endfunction

  function automatic logic is_footer(
    input logic       meta,
    input logic [1:0] kind
  );
    return meta && (kind == META_FOOTER);
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max_v
  );
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/b2b_rr_allocator.sv
// Round-robin output allocator: grants one requester per cycle whose
// destination mask does not touch any currently locked output.
module b2b_rr_allocator #(
  parameter int NI = 4,
  parameter int NO = 14,
  parameter int PW = 2
) (
  input  logic [NI-1:0]         req_i,
  input  logic [NI-1:0][NO-1:0] mask_i,
  input  logic [NO-1:0]         locked_i,
  input  logic [PW-1:0]         ptr_i,
  output logic [NI-1:0]         gnt_o,
  output logic [PW-1:0]         ptr_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    ptr_o = ptr_i;
    found = 1'b0;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (!found && (i == (int'(ptr_i) + k) % NI) && req_i[i]
            && ((mask_i[i] & locked_i) == '0)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          ptr_o    = PW'((i + 1) % NI);
        end
      end
    end
  end

endmodule

// File: rtl/b2b_event_router.sv
// Routes whole events from cluster inputs to board outputs with
// per-event output locking, multicast masks and round-robin grants.
module b2b_event_router
  import b2b_pkg::*;
#(
  parameter int DATA_WIDTH  = 65,
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 14,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_INPUTS-1:0]                  in_valid,
  output logic [NUM_INPUTS-1:0]                  in_ready,
  output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUTPUTS-1:0]                 out_wren,
  input  logic [NUM_OUTPUTS-1:0]                 out_almost_full,
  output logic [CNT_WIDTH-1:0]                   drop_count,
  output logic [CNT_WIDTH-1:0]                   err_count
);

  localparam int NI = NUM_INPUTS;
  localparam int NO = NUM_OUTPUTS;
  localparam int PW = (NI > 1) ? $clog2(NI) : 1;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  input_state_t st_q [NI];
  input_state_t st_d [NI];

  logic [NI-1:0][NO-1:0] mask_q, mask_d, hdr_mask;
  logic [NI-1:0]         first_q, first_d;
  logic [NI-1:0]         hdr, ftr, req, gnt, rdy, acc;
  logic [NO-1:0]         locked_q, locked_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d, err_q, err_d;

  logic [NO-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [NO-1:0]                 wren_q, wren_d;

  always_comb begin
    hdr      = '0;
    ftr      = '0;
    req      = '0;
    hdr_mask = '0;
    for (int i = 0; i < NI; i++) begin
      hdr[i] = is_header(in_data[i][DATA_WIDTH-1],
                         in_data[i][DATA_WIDTH-2 -: 2]);
      ftr[i] = is_footer(in_data[i][DATA_WIDTH-1],
                         in_data[i][DATA_WIDTH-2 -: 2]);
      hdr_mask[i] = in_data[i][NO-1:0];
      req[i] = (st_q[i] == REQ) && in_valid[i];
    end
  end

  b2b_rr_allocator #(
    .NI(NI),
    .NO(NO),
    .PW(PW)
  ) u_alloc (
    .req_i   (req),
    .mask_i  (hdr_mask),
    .locked_i(locked_q),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .ptr_o   (ptr_d)
  );

  always_comb begin
    st_d     = st_q;
    mask_d   = mask_q;
    first_d  = first_q;
    locked_d = locked_q;
    drop_d   = drop_q;
    err_d    = err_q;
    rdy      = '0;
    acc      = '0;
    for (int i = 0; i < NI; i++) begin
      unique case (st_q[i])
        IDLE, DROP: begin
          if (in_valid[i]) begin
            if (hdr[i]) begin
              if (st_q[i] == DROP)
                err_d = CNT_WIDTH'(sat_inc(32'(err_d), CNT_MAX));
              if (hdr_mask[i] != '0) begin
                st_d[i] = REQ;
              end else begin
                rdy[i]  = 1'b1;
                st_d[i] = DROP;
              end
            end else begin
              rdy[i] = 1'b1;
              if (st_q[i] == IDLE) begin
                err_d = CNT_WIDTH'(sat_inc(32'(err_d), CNT_MAX));
              end else if (ftr[i]) begin
                st_d[i] = IDLE;
                drop_d  = CNT_WIDTH'(sat_inc(32'(drop_d), CNT_MAX));
              end
            end
          end
        end
        REQ: begin
          if (gnt[i]) begin
            st_d[i]    = STREAM;
            mask_d[i]  = hdr_mask[i];
            first_d[i] = 1'b1;
            locked_d   = locked_d | hdr_mask[i];
          end
        end
        STREAM: begin
          // Only the granted header may pass; a later one means a lost footer.
          if (in_valid[i] && hdr[i] && !first_q[i]) begin
            st_d[i]  = REQ;
            locked_d = locked_d & ~mask_q[i];
            err_d    = CNT_WIDTH'(sat_inc(32'(err_d), CNT_MAX));
          end else if (in_valid[i]
                       && ((mask_q[i] & out_almost_full) == '0)) begin
            rdy[i]     = 1'b1;
            acc[i]     = 1'b1;
            first_d[i] = 1'b0;
            if (ftr[i]) begin
              st_d[i]  = IDLE;
              locked_d = locked_d & ~mask_q[i];
            end
          end
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    wren_d = '0;
    data_d = data_q;
    for (int i = 0; i < NI; i++) begin
      for (int o = 0; o < NO; o++) begin
        if (acc[i] && mask_q[i][o]) begin
          wren_d[o] = 1'b1;
          data_d[o] = in_data[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q     <= '{default: IDLE};
      mask_q   <= '0;
      first_q  <= '0;
      locked_q <= '0;
      ptr_q    <= '0;
      drop_q   <= '0;
      err_q    <= '0;
      data_q   <= '0;
      wren_q   <= '0;
    end else begin
      st_q     <= st_d;
      mask_q   <= mask_d;
      first_q  <= first_d;
      locked_q <= locked_d;
      ptr_q    <= ptr_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
    end
  end

  assign in_ready   = rdy & {NI{~reset}};
  assign out_data   = data_q;
  assign out_wren   = wren_q;
  assign drop_count = drop_q;
  assign err_count  = err_q;

endmodule
